// File: rtl/cic_interp_pkg.sv
// Shared definitions for the CIC interpolator: port widths, gain-stage limits
// and the elaboration helpers for bit growth and ceiling log2.
package cic_interp_pkg;

  localparam int RATE_W         = 8;
  localparam int GAIN_W         = 3;
  localparam int GAIN_MAX_SHIFT = (1 << GAIN_W) - 1;

  typedef logic [RATE_W-1:0] rate_t;

  // Smallest r with 2**r >= value; value <= 1 yields 0.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Worst-case growth of the last integrator at the maximum rate, in bits.
  function automatic int maxbitgain_f(input int n_stages, input int log2_max_rate);
    return (n_stages - 1) * log2_max_rate;
  endfunction

endpackage

// File: rtl/cic_int_shifter.sv
// Rate-dependent attenuation: arithmetic right shift by ceil(log2(R))*(N-1),
// with R=0 treated as 1 and R above the maximum clamped to the maximum.
module cic_int_shifter
  import cic_interp_pkg::*;
#(
  parameter int bw               = 16,
  parameter int N                = 4,
  parameter int log2_of_max_rate = 7,
  parameter int OUT_W            = bw + GAIN_MAX_SHIFT,
  localparam int W               = bw + maxbitgain_f(N, log2_of_max_rate)
) (
  input  rate_t                   rate,
  input  logic signed [W-1:0]     din,
  output logic signed [OUT_W-1:0] dout
);

  localparam int MAX_RATE = 1 << log2_of_max_rate;

  int rate_eff;
  int log2_sel;

  // Each candidate shift is a constant; the rate only drives the select.
  always_comb begin
    if (rate == '0) begin
      rate_eff = 1;
    end else if (int'(rate) > MAX_RATE) begin
      rate_eff = MAX_RATE;
    end else begin
      rate_eff = int'(rate);
    end
    log2_sel = clog2_f(rate_eff);
    dout     = OUT_W'(din);
    for (int k = 1; k <= log2_of_max_rate; k++) begin
      if (log2_sel == k) dout = OUT_W'(din >>> (k * (N - 1)));
    end
  end

endmodule

// File: rtl/cic_interp.sv
// N-stage variable-rate CIC interpolator: combs on strobe_in, zero-stuffed
// integrators on strobe_out. Optional output gain/saturation: CIC_INTERP_GAIN_EN.
module cic_interp
  import cic_interp_pkg::*;
#(
  parameter int bw               = 16,
  parameter int N                = 4,
  parameter int log2_of_max_rate = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  rate_t                rate,
  input  logic                 strobe_in,
  input  logic                 strobe_out,
  input  logic signed [bw-1:0] signal_in,
`ifdef CIC_INTERP_GAIN_EN
  input  logic [GAIN_W-1:0]    gain_bits,
`endif
  output logic signed [bw-1:0] signal_out
);

  localparam int W = bw + maxbitgain_f(N, log2_of_max_rate);
`ifdef CIC_INTERP_GAIN_EN
  localparam int OUT_W = bw + GAIN_MAX_SHIFT;
`else
  localparam int OUT_W = bw;
`endif

  // Disabling behaves exactly like reset so software can flush by toggling enable.
  logic clear;
  assign clear = reset | ~enable;

  logic signed [W-1:0] in_ext;
  logic signed [W-1:0] inject;
  logic signed [W-1:0] diff_q  [N];
  logic signed [W-1:0] diff_d  [N];
  logic signed [W-1:0] pipe_q  [N];
  logic signed [W-1:0] pipe_d  [N];
  logic signed [W-1:0] integ_q [N];
  logic signed [W-1:0] integ_d [N];

  // ---- comb chain (slow strobe) and integrator chain (fast strobe) ----
  always_comb begin
    in_ext = {{(W-bw){signal_in[bw-1]}}, signal_in};
    inject = strobe_in ? pipe_q[N-1] : {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      diff_d[i]  = diff_q[i];
      pipe_d[i]  = pipe_q[i];
      integ_d[i] = integ_q[i];
    end
    if (strobe_in) begin
      diff_d[0] = in_ext;
      pipe_d[0] = in_ext - diff_q[0];
      for (int i = 1; i < N; i++) begin
        diff_d[i] = pipe_q[i-1];
        pipe_d[i] = pipe_q[i-1] - diff_q[i];
      end
    end
    if (strobe_out) begin
      integ_d[0] = integ_q[0] + inject;
      for (int i = 1; i < N; i++) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        diff_q[i]  <= '0;
        pipe_q[i]  <= '0;
        integ_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        diff_q[i]  <= diff_d[i];
        pipe_q[i]  <= pipe_d[i];
        integ_q[i] <= integ_d[i];
      end
    end
  end

  logic signed [OUT_W-1:0] scaled_wide;

  cic_int_shifter #(
    .bw               (bw),
    .N                (N),
    .log2_of_max_rate (log2_of_max_rate),
    .OUT_W            (OUT_W)
  ) u_shifter (
    .rate (rate),
    .din  (integ_q[N-1]),
    .dout (scaled_wide)
  );

  logic signed [bw-1:0] out_q;
  logic signed [bw-1:0] out_d;

`ifdef CIC_INTERP_GAIN_EN
  // Left shift by up to GAIN_MAX_SHIFT, clipped to the bw-bit signed range.
  function automatic logic signed [bw-1:0] sat_shift_f(input logic signed [OUT_W-1:0] v,
                                                       input logic [GAIN_W-1:0]      g);
    logic signed [OUT_W+GAIN_MAX_SHIFT-1:0] wide;
    logic [OUT_W+GAIN_MAX_SHIFT-bw:0]       top;
    wide = {{GAIN_MAX_SHIFT{v[OUT_W-1]}}, v};
    wide = wide <<< g;
    top  = wide[OUT_W+GAIN_MAX_SHIFT-1:bw-1];
    if ((top == '0) || (top == '1)) begin
      return wide[bw-1:0];
    end else if (wide[OUT_W+GAIN_MAX_SHIFT-1]) begin
      return {1'b1, {(bw-1){1'b0}}};
    end else begin
      return {1'b0, {(bw-1){1'b1}}};
    end
  endfunction

  logic [GAIN_W-1:0]       gain_q;
  logic [GAIN_W-1:0]       gain_d;
  logic                    vld_p1_q;
  logic                    vld_p1_d;
  logic signed [OUT_W-1:0] scaled_p1_q;
  logic signed [OUT_W-1:0] scaled_p1_d;

  // ---- p1: capture scaled sample and gain; p2: shift, clip, present ----
  always_comb begin
    gain_d      = gain_bits;
    vld_p1_d    = strobe_out;
    scaled_p1_d = strobe_out ? scaled_wide : scaled_p1_q;
    out_d       = vld_p1_q ? sat_shift_f(scaled_p1_q, gain_q) : out_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      gain_q      <= '0;
      vld_p1_q    <= 1'b0;
      scaled_p1_q <= '0;
      out_q       <= '0;
    end else begin
      gain_q      <= gain_d;
      vld_p1_q    <= vld_p1_d;
      scaled_p1_q <= scaled_p1_d;
      out_q       <= out_d;
    end
  end
`else
  // ---- output register: loads on each strobe_out, holds otherwise ----
  always_comb begin
    out_d = strobe_out ? scaled_wide : out_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end
`endif

  assign signal_out = out_q;

endmodule

// File: tb/tb_cic_interp.sv
// Scoreboard bench for cic_interp: closed-form binomial reference model,
// directed scenarios plus randomized strobe/data/rate segments.
module tb_cic_interp;

  localparam int BW       = 16;
  localparam int NS       = 4;
  localparam int L2       = 7;
  localparam int W        = BW + (NS - 1) * L2;
  localparam int MAX_RATE = 1 << L2;
`ifdef CIC_INTERP_GAIN_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [7:0]           rate;
  logic                 strobe_in;
  logic                 strobe_out;
  logic signed [BW-1:0] signal_in;
  logic [2:0]           gain_bits;
  logic signed [BW-1:0] signal_out;

  always #5 clock = ~clock;

  cic_interp #(
    .bw               (BW),
    .N                (NS),
    .log2_of_max_rate (L2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .strobe_out (strobe_out),
    .signal_in  (signal_in),
`ifdef CIC_INTERP_GAIN_EN
    .gain_bits  (gain_bits),
`endif
    .signal_out (signal_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;
  logic signed [BW-1:0] exp_q[$];

  // Reference model state: inputs since the last clear, injected comb outputs
  // tagged with their strobe_out index, and the output-stage registers.
  longint x_hist[$];
  int     ev_t[$];
  longint ev_u[$];
  int     m_t;
  longint m_out;
  bit     m_pvld;
  longint m_pval;
  int     m_gprev;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic longint choose(input int n, input int k);
    longint c;
    if (k < 0 || n < k) return 0;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  function automatic longint wrap_w(input longint v);
    longint s;
    s = v <<< (64 - W);
    return s >>> (64 - W);
  endfunction

  // N-th backward difference of the input sequence at index j (zero before start).
  function automatic longint comb_at(input int j);
    longint acc;
    int idx;
    acc = 0;
    for (int k = 0; k <= NS; k++) begin
      idx = j - k;
      if (idx >= 0 && idx < x_hist.size()) begin
        if (k % 2 == 1) acc = acc - choose(NS, k) * x_hist[idx];
        else            acc = acc + choose(NS, k) * x_hist[idx];
      end
    end
    return acc;
  endfunction

  // N-fold running sum (one strobe delay per stage) seen just before strobe t.
  function automatic longint y_at(input int t);
    longint acc;
    acc = 0;
    for (int e = 0; e < ev_t.size(); e++) begin
      if (ev_t[e] < t) acc = acc + choose(t - 1 - ev_t[e], NS - 1) * ev_u[e];
    end
    return wrap_w(acc);
  endfunction

  function automatic longint scale_r(input longint y, input int r);
    int rr;
    int cl;
    rr = (r == 0) ? 1 : ((r > MAX_RATE) ? MAX_RATE : r);
    cl = 0;
    while ((1 << cl) < rr) cl++;
    return y >>> (cl * (NS - 1));
  endfunction

  task automatic model_edge();
    longint y;
    longint sw;
    logic signed [BW-1:0]   t16;
    logic signed [BW+6:0]   t23;
    longint g;
    sw = 0;
    if (reset || !enable) begin
      x_hist.delete(); ev_t.delete(); ev_u.delete();
      m_t = 0; m_out = 0; m_pvld = 0; m_pval = 0; m_gprev = 0;
    end else begin
      if (strobe_out) begin
        y  = y_at(m_t);
        sw = scale_r(y, int'(rate));
        if (strobe_in) begin
          y = wrap_w(comb_at(x_hist.size() - NS));
          if (y != 0) begin
            ev_t.push_back(m_t);
            ev_u.push_back(y);
          end
        end
        m_t++;
      end
      if (strobe_in) x_hist.push_back(longint'(signal_in));
`ifdef CIC_INTERP_GAIN_EN
      if (m_pvld) begin
        g = m_pval <<< m_gprev;
        if (g > 32767) g = 32767;
        else if (g < -32768) g = -32768;
        m_out = g;
      end
      m_pvld = strobe_out;
      if (strobe_out) begin
        t23 = sw[BW+6:0];
        m_pval = longint'(t23);
      end
      m_gprev = int'(gain_bits);
`else
      if (strobe_out) begin
        t16 = sw[BW-1:0];
        m_out = longint'(t16);
      end
`endif
    end
    t16 = m_out[BW-1:0];
    exp_q.push_back(t16);
  endtask

  task automatic cyc(input bit rst, input bit en, input int r, input bit si, input bit so, input longint x);
    reset      = rst;
    enable     = en;
    rate       = r[7:0];
    strobe_in  = si;
    strobe_out = so;
    signal_in  = x[BW-1:0];
    model_edge();
    @(negedge clock);
  endtask

  task automatic run_rate(input int r, input longint x, input int ncyc);
    int reff;
    reff = (r == 0) ? 1 : ((r > MAX_RATE) ? MAX_RATE : r);
    for (int c = 0; c < ncyc; c++) cyc(1'b0, 1'b1, r, (c % reff) == 0, 1'b1, x);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
  endtask

  // Monitor: the output register can move on every edge, so one expectation per edge.
  initial begin
    logic signed [BW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (done) break;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got no expectation, expected one (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", signal_out, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int reff;
    int ph;
    bit si;
    bit so;
    gain_bits = 3'd0;
    do_reset();
    do_reset();
    chk("reset_state", signal_out, 0);

    // Reset while running, then stays at zero.
    run_rate(4, 1000, 200);
    chk("r4_dc1000_pre_reset", signal_out, 1000);
    cyc(1'b1, 1'b1, 4, 1'b0, 1'b1, 0);
    chk("reset_clears_out", signal_out, 0);
    run_rate(4, 0, 40);
    chk("after_reset_zero", signal_out, 0);

    // R=1 impulse: single 1 at 2N strobes (+ gain stage) after the impulse.
    do_reset();
    cyc(1'b0, 1'b1, 1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 2 * NS - 1 + LAT_EXTRA; i++) cyc(1'b0, 1'b1, 1, 1'b1, 1'b1, 0);
    chk("impulse_before", signal_out, 0);
    cyc(1'b0, 1'b1, 1, 1'b1, 1'b1, 0);
    chk("impulse_peak", signal_out, 1);
    cyc(1'b0, 1'b1, 1, 1'b1, 1'b1, 0);
    chk("impulse_after", signal_out, 0);
    run_rate(1, 0, 30);
    chk("impulse_tail", signal_out, 0);

    // R=4 DC levels including the negative full-scale.
    do_reset();
    run_rate(4, 1000, 200);
    chk("r4_dc1000", signal_out, 1000);
    run_rate(4, -32768, 200);
    chk("r4_dc_neg_full", signal_out, -32768);

    // Non-power-of-two rate attenuation and the maximum rate.
    do_reset();
    run_rate(5, 32767, 250);
    chk("r5_dc_max", signal_out, 7999);
    do_reset();
    run_rate(128, 32767, 1600);
    chk("r128_dc_max", signal_out, 32767);

    // Enable dropped for three clocks mid-stream, then a clean restart.
    do_reset();
    run_rate(4, 1000, 100);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4, (i == 0), 1'b1, 1000);
    chk("disabled_out_zero", signal_out, 0);
    run_rate(4, 1000, 4);
    chk("restart_from_zero", signal_out, 0);
    run_rate(4, 1000, 200);
    chk("restart_settles", signal_out, 1000);

`ifdef CIC_INTERP_GAIN_EN
    gain_bits = 3'd2;
    do_reset();
    run_rate(4, 1000, 200);
    chk("gain_x4", signal_out, 4000);
    do_reset();
    run_rate(4, 16000, 200);
    chk("gain_sat_pos", signal_out, 32767);
    do_reset();
    run_rate(4, -16000, 200);
    chk("gain_sat_neg", signal_out, -32768);
    gain_bits = 3'd0;
`endif

    // Randomized segments: rate (incl. 0 and above max), idle gaps, dropped samples.
    for (int seg = 0; seg < 8; seg++) begin
      case ($urandom_range(0, 7))
        0: r = 0;
        1: r = 1;
        2: r = 2;
        3: r = 3;
        4: r = 5;
        5: r = 8;
        6: r = 16;
        default: r = 200;
      endcase
      do_reset();
      ph = 0;
      for (int c = 0; c < 260; c++) begin
        if (seg == 3 && c == 130) r = 6;
        reff = (r == 0) ? 1 : ((r > MAX_RATE) ? MAX_RATE : r);
        so = ($urandom_range(0, 9) != 0);
        si = so && (ph == 0);
        if (!so && $urandom_range(0, 39) == 0) si = 1'b1;
        if (so) ph = (ph + 1 >= reff) ? 0 : ph + 1;
`ifdef CIC_INTERP_GAIN_EN
        gain_bits = 3'($urandom_range(0, 7));
`endif
        cyc(1'b0, 1'b1, r, si, so, longint'($signed(16'($urandom))));
      end
    end

    done = 1'b1;
    @(posedge clock);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
